load_store_unit: RTL and testbench

Core-side initiator for the word-only, word-aligned data memory: it converts byte, halfword and word loads and stores from the datapath into word accesses.
- Sub-word stores use read-modify-write, because the memory has only a word write enable.
- Loads are lane-extracted and sign- or zero-extended.
- Sits between the execute stage and data_memory, and exposes a stall-friendly valid/ready request with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/load_store_unit_byte_lane_align.sv | 56 +++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   access_size_t : encoding of the core's req_size field
//   lsu_state_t   : controller states of the load/store unit
//   is_misaligned : alignment/legality test for a request
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  // A request is rejected when its size is illegal or its address is not a
  // multiple of the access size. Bytes can never be misaligned.
  function automatic logic is_misaligned(input access_size_t size,
                                         input logic [1:0]   addr_lo);
    logic bad;
    unique case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_align.sv
// ---------------------------------------------------------------------------
// byte_lane_align
// Purely combinational lane steering between a 32-bit memory word and the
// core's sub-word data (little-endian lanes).
//   i_size        : access size
//   i_unsigned    : zero-extend loads when 1, sign-extend when 0
//   i_lane        : byte address bits [1:0]
//   i_mem_word    : word read from memory
//   i_store_data  : store data, right-justified
//   o_load_value  : lane extracted and extended for the core
//   o_merged_word : i_mem_word with only the addressed lane(s) replaced
// ---------------------------------------------------------------------------
module byte_lane_align
  import lsu_pkg::*;
(
  input  access_size_t i_size,
  input  logic         i_unsigned,
  input  logic [1:0]   i_lane,
  input  logic [31:0]  i_mem_word,
  input  logic [31:0]  i_store_data,
  output logic [31:0]  o_load_value,
  output logic [31:0]  o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    w_byte        = i_mem_word[8*i_lane +: 8];
    w_half        = i_lane[1] ? i_mem_word[31:16] : i_mem_word[15:0];
    o_load_value  = '0;
    o_merged_word = i_mem_word;

    unique case (i_size)
      SIZE_BYTE: begin
        o_load_value = i_unsigned ? {24'd0, w_byte}
                                  : {{24{w_byte[7]}}, w_byte};
        o_merged_word[8*i_lane +: 8] = i_store_data[7:0];
      end
      SIZE_HALF: begin
        o_load_value = i_unsigned ? {16'd0, w_half}
                                  : {{16{w_half[15]}}, w_half};
        if (i_lane[1]) o_merged_word[31:16] = i_store_data[15:0];
        else           o_merged_word[15:0]  = i_store_data[15:0];
      end
      SIZE_WORD: begin
        o_load_value  = i_mem_word;
        o_merged_word = i_store_data;
      end
      default: ;  // illegal size never reaches the datapath
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Converts byte/half/word loads and stores from the core into accesses to a
// word-only, word-aligned data memory. Sub-word stores are done as
// read-modify-write. One request outstanding; one-cycle response pulse.
//   clock, reset_n            : clock, asynchronous active-low reset
//   req_valid / req_ready     : request handshake (transfer when both high)
//   req_write, req_size,
//   req_unsigned, req_address,
//   req_write_data            : request fields, sampled on transfer only
//   resp_valid                : one-cycle completion pulse
//   resp_read_data, resp_error: response payload, held until next response
//   mem_address               : aligned word address (bits [1:0] = 00)
//   mem_write_enable          : write strobe, high only in WRITE
//   mem_write_data            : full word to write
//   mem_read_data             : combinational read data for mem_address
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int address_width = 32,
  parameter int word_width    = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [address_width-1:0] req_address,
  input  logic [word_width-1:0]    req_write_data,
  output logic                     resp_valid,
  output logic [word_width-1:0]    resp_read_data,
  output logic                     resp_error,
  output logic [address_width-1:0] mem_address,
  output logic                     mem_write_enable,
  output logic [word_width-1:0]    mem_write_data,
  input  logic [word_width-1:0]    mem_read_data
);

  // The lane logic is built for 32-bit words only.
  if (word_width != 32) begin : g_bad_word_width
    $error("load_store_unit: word_width must be 32");
  end

  lsu_state_t                r_state;
  lsu_state_t                w_next_state;
  logic                      r_write;
  access_size_t              r_size;
  logic                      r_unsigned;
  logic [address_width-1:0]  r_addr;
  logic [word_width-1:0]     r_wdata;      // store data, later the merged word
  logic [word_width-1:0]     r_resp_data;
  logic                      r_resp_error;

  logic                      w_accept;
  access_size_t              w_req_size;
  logic                      w_req_error;
  logic [word_width-1:0]     w_load_value;
  logic [word_width-1:0]     w_merged_word;

  assign w_accept    = req_valid & req_ready;
  assign w_req_size  = access_size_t'(req_size);
  assign w_req_error = is_misaligned(w_req_size, req_address[1:0]);

  byte_lane_align u_align (
    .i_size        (r_size),
    .i_unsigned    (r_unsigned),
    .i_lane        (r_addr[1:0]),
    .i_mem_word    (mem_read_data),
    .i_store_data  (r_wdata),
    .o_load_value  (w_load_value),
    .o_merged_word (w_merged_word)
  );

  // State register. Reset is asynchronous so an in-flight write strobe drops
  // immediately and the pending store is abandoned.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_error)                               w_next_state = RESP;
          else if (req_write && w_req_size == SIZE_WORD) w_next_state = WRITE;
          else                                           w_next_state = READ;
        end
      end
      READ:    w_next_state = r_write ? WRITE : RESP;
      WRITE:   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so they are glitch-free.
  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    unique case (r_state)
      IDLE:    req_ready        = 1'b1;
      WRITE:   mem_write_enable = 1'b1;
      RESP:    resp_valid       = 1'b1;
      default: ;
    endcase
  end

  // Request latch and response payload.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write      <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_size     <= w_req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_address;
            r_wdata    <= req_write_data;
            if (w_req_error) begin
              r_resp_data  <= '0;
              r_resp_error <= 1'b1;
            end
          end
        end
        READ: begin
          if (r_write) begin
            r_wdata <= w_merged_word;
          end else begin
            r_resp_data  <= w_load_value;
            r_resp_error <= 1'b0;
          end
        end
        WRITE: begin
          r_resp_data  <= '0;
          r_resp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_address    = {r_addr[address_width-1:2], 2'b00};
  assign mem_write_data = r_wdata;
  assign resp_read_data = r_resp_data;
  assign resp_error     = r_resp_error;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: a small word memory attached to the unit, directed
// cases for the key scenarios, then random requests checked against a
// transaction-level reference model (shadow memory plus shift/mask rules).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  always #5 clock = ~clock;

  load_store_unit #(.address_width(32), .word_width(32)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_address      (req_address),
    .req_write_data   (req_write_data),
    .resp_valid       (resp_valid),
    .resp_read_data   (resp_read_data),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Data memory: combinational read, synchronous word write.
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clock) begin
    if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_err(input int size, input logic [31:0] addr);
    return (size == 3) || (size == 1 && addr[0]) ||
           (size == 2 && addr[1:0] != 2'b00);
  endfunction

  function automatic int lane_shift(input int size, input logic [31:0] addr);
    return (size == 0) ? 8 * int'(addr[1:0]) : (size == 1) ? 16 * int'(addr[1]) : 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int size,
                                             input logic [31:0] addr, input bit uns);
    logic [31:0] v;
    v = word >> lane_shift(size, addr);
    if (size == 0) begin
      v = v & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = v & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input int size,
                                              input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] mask;
    int          sh;
    sh   = lane_shift(size, addr);
    mask = (size == 0) ? (32'hFF << sh) : (size == 1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
    return (word & ~mask) | ((data << sh) & mask);
  endfunction

  // One full transaction: handshake, monitor until the response, compare.
  task automatic do_req(input string tag, input bit wr, input int size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] got_data);
    logic [31:0] exp_data, exp_wdata, old_word;
    int          exp_lat, exp_we, lat, we_cnt, busy_ready, idx, k;
    logic [31:0] wa, wd;
    bit          err;

    idx      = int'(addr[7:2]);
    old_word = ref_mem[idx];
    err      = model_err(size, addr);
    exp_wdata = 32'h0;
    if (err) begin
      exp_data = 0; exp_lat = 1; exp_we = 0;
    end else if (!wr) begin
      exp_data = model_load(old_word, size, addr, uns); exp_lat = 2; exp_we = 0;
    end else begin
      exp_wdata    = model_store(old_word, size, addr, data);
      ref_mem[idx] = exp_wdata;
      exp_data = 0; exp_lat = (size == 2) ? 2 : 3; exp_we = 1;
    end

    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = size[1:0];
    req_unsigned = uns; req_address = addr; req_write_data = data;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clock); k++; end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      got_data  = 'x;
      return;
    end
    @(posedge clock);

    lat = 0; we_cnt = 0; busy_ready = 0; wa = 0; wd = 0; got_data = 'x;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      if (n == 1) begin
        req_valid = 1'b0;
        req_write = $urandom; req_size = 2'($urandom); req_address = $urandom;
      end
      if (req_ready) busy_ready++;
      if (mem_write_enable) begin we_cnt++; wa = mem_address; wd = mem_write_data; end
      if (resp_valid) begin lat = n; got_data = resp_read_data; break; end
    end
    check({tag, "_latency"},    32'(lat), 32'(exp_lat));
    check({tag, "_ready_busy"}, 32'(busy_ready), 32'd0);
    check({tag, "_resp_error"}, 32'(resp_error), 32'(err));
    check({tag, "_read_data"},  got_data, exp_data);
    check({tag, "_we_pulses"},  32'(we_cnt), 32'(exp_we));
    if (exp_we == 1) begin
      check({tag, "_wr_addr"}, wa, {addr[31:2], 2'b00});
      check({tag, "_wr_data"}, wd, exp_wdata);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          diffs;

    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_address = 0; req_write_data = 0;

    // Reset values.
    #12;
    check("rst_req_ready",  32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  resp_read_data, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_mem_we",     32'(mem_write_enable), 32'd0);
    check("rst_mem_addr",   mem_address, 32'd0);
    check("rst_mem_wdata",  mem_write_data, 32'd0);
    @(negedge clock); reset_n = 1'b1;

    // Directed loads.
    do_req("lb_s_11", 0, 0, 0, 32'h11, 32'h0, got);
    check("lb_s_11_const", got, 32'hFFFF_FFAA);
    do_req("lhu_12", 0, 1, 1, 32'h12, 32'h0, got);
    check("lhu_12_const", got, 32'h0000_8899);
    do_req("lw_10", 0, 2, 0, 32'h10, 32'h0, got);
    check("lw_10_const", got, 32'h8899_AABB);

    // Byte store via read-modify-write, then read back.
    do_req("sb_13", 1, 0, 0, 32'h13, 32'h5C, got);
    check("sb_13_mem", mem[4], 32'h5C99_AABB);
    do_req("lw_10_after_sb", 0, 2, 0, 32'h10, 32'h0, got);
    check("lw_10_after_sb_const", got, 32'h5C99_AABB);

    // Errors: misaligned word store and illegal size.
    do_req("sw_16_err", 1, 2, 0, 32'h16, 32'hDEAD_BEEF, got);
    check("sw_16_err_mem", mem[5], ref_mem[5]);
    @(negedge clock);
    check("err_hold_resp_error", 32'(resp_error), 32'd1);
    check("err_hold_resp_valid", 32'(resp_valid), 32'd0);
    do_req("size3_err", 0, 3, 0, 32'h10, 32'h0, got);

    // Restore word 0x10 with a word store.
    do_req("sw_10", 1, 2, 0, 32'h10, 32'h8899_AABB, got);
    check("sw_10_mem", mem[4], 32'h8899_AABB);

    // Reset asserted during the WRITE cycle of a half store.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_address = 32'h10; req_write_data = 32'h1234;
    check("rstw_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock); req_valid = 1'b0;          // READ
    @(negedge clock);                             // WRITE
    check("rstw_we_in_write", 32'(mem_write_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstw_we_async_drop", 32'(mem_write_enable), 32'd0);
    diffs = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      if (resp_valid) diffs++;
    end
    reset_n = 1'b1;
    check("rstw_no_resp", 32'(diffs), 32'd0);
    @(posedge clock); #1;
    check("rstw_mem_kept", mem[4], 32'h8899_AABB);
    check("rstw_ready_after", 32'(req_ready), 32'd1);
    check("rstw_no_resp_after", 32'(resp_valid), 32'd0);

    // Back-to-back loads with req_valid held high.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_address = 32'h10;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    @(negedge clock);                             // first READ
    req_size = 2'b01; req_address = 32'h12;       // second request, still valid
    check("b2b_ready_read", 32'(req_ready), 32'd0);
    @(negedge clock);                             // first RESP
    check("b2b_resp1_valid", 32'(resp_valid), 32'd1);
    check("b2b_resp1_data", resp_read_data, 32'h8899_AABB);
    check("b2b_ready_resp", 32'(req_ready), 32'd0);
    @(negedge clock);                             // IDLE, second accepted next edge
    check("b2b_ready_idle", 32'(req_ready), 32'd1);
    check("b2b_gap_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);                             // second READ
    req_valid = 1'b0;
    check("b2b_ready_read2", 32'(req_ready), 32'd0);
    @(negedge clock);                             // second RESP
    check("b2b_resp2_valid", 32'(resp_valid), 32'd1);
    check("b2b_resp2_data", resp_read_data, 32'hFFFF_8899);

    // Random traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      int          sz;
      bit          wr, uns;
      logic [31:0] addr, data;
      sz   = $urandom_range(0, 3);
      wr   = 1'($urandom);
      uns  = 1'($urandom);
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        // Mostly aligned, so the memory path gets exercised.
        if (sz == 1) addr[0] = 1'b0;
        if (sz == 2) addr[1:0] = 2'b00;
      end
      data = $urandom;
      do_req("rnd", wr, sz, uns, addr, data, got);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("final_mem_diffs", 32'(diffs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
